door_arbiter: RTL
=================

DOOR_ARBITER -- requirements
Module: door_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles a grant may wait for SENSOR before an alarm is raised.
REQ-002 Parameter ALARM_LEN, default 8: cycles the alarm state is held.
REQ-003 Parameter MAX_OCC, default 9: occupancy limit, 1..15.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 REQ_IN  input  1  entry request (person waiting outside); level, synchronous to CLK.
REQ-007 REQ_OUT  input  1  exit request (person waiting inside); level, synchronous to CLK.
REQ-008 SENSOR  input  1  passage sensor, high while a person is in the door.
REQ-009 GRANT_IN  output  1  door turning inward.
REQ-010 GRANT_OUT  output  1  door turning outward.
REQ-011 LEDG  output  1  green light; equals GRANT_IN | GRANT_OUT.
REQ-012 LEDR  output  2  LEDR[0] red light (alarm or full-with-pending-entry); LEDR[1] sounder (alarm only).
REQ-013 OCC  output  4  current occupancy count.
REQ-014 FULL  output  1  high when OCC == MAX_OCC.
REQ-015 STATE  output  3  encoded FSM state, for the board display.

Function
REQ-016 States: IDLE=0, G_IN=1, G_OUT=2, PASS_IN=3, PASS_OUT=4, ALARM=5; all other codes return to IDLE on the next edge.
REQ-017 IDLE, entry only: REQ_IN && !FULL -> G_IN.
REQ-018 IDLE, exit only: REQ_OUT -> G_OUT.
REQ-019 IDLE, both eligible: grant the direction opposite to the last one served (round-robin flag LAST, reset value = OUT, so the first tie goes to IN).
REQ-020 IDLE with REQ_IN && FULL and no REQ_OUT: remain in IDLE; LEDR[0]=1 while this condition holds.
REQ-021 G_IN / G_OUT: SENSOR==1 -> PASS_IN / PASS_OUT; otherwise the wait counter increments; counter reaching TIMEOUT-1 with SENSOR==0 -> ALARM.
REQ-022 Request deassertion during G_IN / G_OUT does not revoke the grant; only SENSOR or the timeout exits the state.
REQ-023 PASS_IN / PASS_OUT: hold until SENSOR==0; on that edge go to IDLE, update LAST, and update OCC.
REQ-024 OCC update: +1 on PASS_IN exit, saturating at MAX_OCC; -1 on PASS_OUT exit, saturating at 0; no other event changes OCC.
REQ-025 ALARM: LEDR=2'b11, both grants low, stay ALARM_LEN cycles, then IDLE; LAST is updated as if the grant had been served; OCC is unchanged.
REQ-026 Grant outputs are registered and decode state directly: GRANT_IN=1 in G_IN and PASS_IN, GRANT_OUT=1 in G_OUT and PASS_OUT; never both high.
REQ-027 Latency: a request sampled in IDLE produces its grant on the following cycle.
REQ-028 The wait/alarm counter is cleared on every state change; it is at least 8 bits wide.
REQ-029 SENSOR high while in IDLE or ALARM is ignored and causes no count change.

Reset
REQ-030 RST_N low forces, asynchronously: STATE=IDLE, OCC=0, LAST=OUT, counter=0, GRANT_IN=GRANT_OUT=0, LEDG=0, LEDR=0, FULL=0.
REQ-031 Reset asserted mid-passage discards the pass with no OCC update; after release the FSM starts in IDLE.

Verification
REQ-032 Reset, REQ_IN=1 for 1 cycle, SENSOR 1 for 3 cycles then 0 -> GRANT_IN next cycle, IDLE after SENSOR falls, OCC=1, LEDG high throughout the pass.
REQ-033 REQ_IN=REQ_OUT=1 held, OCC=2, four passes -> grants alternate IN, OUT, IN, OUT; final OCC=2.
REQ-034 REQ_IN=1, SENSOR held 0 -> GRANT_IN for 16 cycles, then ALARM with LEDR=11 for 8 cycles, then IDLE; OCC unchanged.
REQ-035 Nine entry passes, then REQ_IN=1 -> OCC=9, FULL=1, no grant, LEDR[0]=1; assert REQ_OUT -> GRANT_OUT; one exit pass -> OCC=8, FULL=0.
REQ-036 OCC=0, one exit pass -> OCC stays 0, no underflow.
REQ-037 RST_N pulsed low during PASS_IN -> all outputs 0 immediately, OCC=0, STATE=IDLE after release.

Source files
------------

// File: rtl/door_arbiter.sv
// rtl/door_arbiter.sv - two-way turnstile arbiter with occupancy count and passage timeout alarm
module door_arbiter #(
  parameter int TIMEOUT   = 16,
  parameter int ALARM_LEN = 8,
  parameter int MAX_OCC   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_in,
  input  logic       req_out,
  input  logic       sensor,
  output logic       grant_in,
  output logic       grant_out,
  output logic       ledg,
  output logic [1:0] ledr,
  output logic [3:0] occ,
  output logic       full,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_G_IN     = 3'd1,
    S_G_OUT    = 3'd2,
    S_PASS_IN  = 3'd3,
    S_PASS_OUT = 3'd4,
    S_ALARM    = 3'd5
  } state_t;

  // Wide enough for the larger of the two hold intervals, never narrower than 8 bits.
  localparam int MAXLEN = (TIMEOUT > ALARM_LEN) ? TIMEOUT : ALARM_LEN;
  localparam int CW     = ($clog2(MAXLEN + 1) > 8) ? $clog2(MAXLEN + 1) : 8;

  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_LEN - 1);
  localparam logic [3:0]    OCC_MAX    = 4'(MAX_OCC);

  state_t        st;
  state_t        st_nx;
  logic [CW-1:0] cnt;
  logic [3:0]    occ_r;
  // last_out: 1 when the most recently served direction was outward.
  logic          last_out;
  // dir_out: direction of the grant currently in progress, remembered so an
  // alarm can still update the round-robin flag.
  logic          dir_out;
  logic          in_ok;
  logic          pass_done;

  assign in_ok     = req_in && !full;
  assign pass_done = ((st == S_PASS_IN) || (st == S_PASS_OUT)) && !sensor;

  // Next-state decode; requests only matter in IDLE, sensor only in grant/pass states.
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE: begin
        if (in_ok && req_out) begin
          st_nx = last_out ? S_G_IN : S_G_OUT;
        end else if (in_ok) begin
          st_nx = S_G_IN;
        end else if (req_out) begin
          st_nx = S_G_OUT;
        end
      end
      S_G_IN: begin
        if (sensor) begin
          st_nx = S_PASS_IN;
        end else if (cnt == TO_LAST) begin
          st_nx = S_ALARM;
        end
      end
      S_G_OUT: begin
        if (sensor) begin
          st_nx = S_PASS_OUT;
        end else if (cnt == TO_LAST) begin
          st_nx = S_ALARM;
        end
      end
      S_PASS_IN: begin
        if (!sensor) begin
          st_nx = S_IDLE;
        end
      end
      S_PASS_OUT: begin
        if (!sensor) begin
          st_nx = S_IDLE;
        end
      end
      S_ALARM: begin
        if (cnt == ALARM_LAST) begin
          st_nx = S_IDLE;
        end
      end
      default: st_nx = S_IDLE;
    endcase
  end

  // State register and registered grant decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      grant_in  <= 1'b0;
      grant_out <= 1'b0;
    end else begin
      st        <= st_nx;
      grant_in  <= (st_nx == S_G_IN)  || (st_nx == S_PASS_IN);
      grant_out <= (st_nx == S_G_OUT) || (st_nx == S_PASS_OUT);
    end
  end

  // Wait/alarm counter: restarts on any state change, runs while waiting for the sensor or alarming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (st_nx != st) begin
      cnt <= '0;
    end else if ((((st == S_G_IN) || (st == S_G_OUT)) && !sensor) || (st == S_ALARM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Round-robin bookkeeping: remember the granted direction, commit it when served or timed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_out <= 1'b1;
      dir_out  <= 1'b0;
    end else begin
      if (st == S_IDLE && st_nx == S_G_IN) begin
        dir_out <= 1'b0;
      end else if (st == S_IDLE && st_nx == S_G_OUT) begin
        dir_out <= 1'b1;
      end
      if (pass_done) begin
        last_out <= (st == S_PASS_OUT);
      end else if (st == S_ALARM && st_nx == S_IDLE) begin
        last_out <= dir_out;
      end
    end
  end

  // Occupancy: changes only when a passage completes, saturating at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= 4'd0;
    end else if (pass_done && st == S_PASS_IN) begin
      if (occ_r != OCC_MAX) begin
        occ_r <= occ_r + 4'd1;
      end
    end else if (pass_done && st == S_PASS_OUT) begin
      if (occ_r != 4'd0) begin
        occ_r <= occ_r - 4'd1;
      end
    end
  end

  assign occ     = occ_r;
  assign full    = (occ_r == OCC_MAX);
  assign ledg    = grant_in | grant_out;
  assign ledr[1] = (st == S_ALARM);
  assign ledr[0] = (st == S_ALARM) || ((st == S_IDLE) && req_in && full && !req_out);
  assign state   = st;

endmodule
